tank_shell: RTL and testbench

- Projectile stage directly downstream of the player tank block.
- Consumes the tank's position, size and facing direction, plus the raw keycode.
- On a fire-key press, launches one shell from the tank's muzzle and moves it one step per frame in the facing direction.
- Retires the shell on a hit or at the screen edge, then enforces a cooldown. Outputs feed the sprite/colour mapper and the hit-detection logic.

---
 rtl/tank_shell.sv | 105 ++++++++++
 tb/tb_tank_shell.sv | 132 +++++++++++++
 2 files changed

// File: rtl/tank_shell.sv
// tank_shell: single-shell projectile launched from the tank muzzle, stepped once per frame,
// retired on hit or screen edge, followed by a fixed cooldown before the next launch.
module tank_shell #(
  parameter logic [7:0] FIRE_KEY        = 8'h2C,
  parameter logic [9:0] SHELL_SIZE      = 10'd2,
  parameter logic [9:0] SHELL_STEP      = 10'd4,
  parameter logic [5:0] COOLDOWN_FRAMES = 6'd30,
  parameter logic [9:0] X_MIN           = 10'd1,
  parameter logic [9:0] X_MAX           = 10'd639,
  parameter logic [9:0] Y_MIN           = 10'd1,
  parameter logic [9:0] Y_MAX           = 10'd479
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] TankS,
  input  logic [1:0] direction,
  input  logic       shell_hit,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic [9:0] ShellS,
  output logic       shell_active,
  output logic       shell_fired
);
  typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN} state_t;
  localparam logic [11:0] XMN  = {2'b0, X_MIN};
  localparam logic [11:0] XMX  = {2'b0, X_MAX};
  localparam logic [11:0] YMN  = {2'b0, Y_MIN};
  localparam logic [11:0] YMX  = {2'b0, Y_MAX};
  localparam logic [11:0] STEP = {2'b0, SHELL_STEP};
  state_t      r_state, w_next;
  logic [1:0]  r_dir;
  logic [9:0]  r_x, r_y;
  logic [5:0]  r_cd;
  logic        r_key_prev, r_fired;
  logic        w_key, w_fire, w_uflow, w_spawn_ok, w_edge, w_launch, w_retire;
  logic [11:0] w_off, w_tx, w_ty, w_sx, w_sy, w_x, w_y;
  logic [9:0]  w_mx, w_my;
  assign w_key  = keycode == FIRE_KEY;
  assign w_fire = w_key && !r_key_prev;
  // Spawn math is widened so a muzzle past the left/top edge shows up as underflow, not wrap.
  assign w_off  = {2'b0, TankS} + {2'b0, SHELL_SIZE} + 12'd1;
  assign w_tx   = {2'b0, TankX};
  assign w_ty   = {2'b0, TankY};
  assign w_sx   = direction == 2'b00 ? w_tx - w_off : direction == 2'b01 ? w_tx + w_off : w_tx;
  assign w_sy   = direction == 2'b10 ? w_ty + w_off : direction == 2'b11 ? w_ty - w_off : w_ty;
  assign w_uflow = (direction == 2'b00 && w_off > w_tx) || (direction == 2'b11 && w_off > w_ty);
  assign w_spawn_ok = !w_uflow && w_sx >= XMN && w_sx <= XMX && w_sy >= YMN && w_sy <= YMX;
  assign w_x    = {2'b0, r_x};
  assign w_y    = {2'b0, r_y};
  assign w_edge = r_dir == 2'b00 ? w_x < XMN + STEP :
                  r_dir == 2'b01 ? w_x + STEP > XMX :
                  r_dir == 2'b10 ? w_y + STEP > YMX : w_y < YMN + STEP;
  assign w_mx   = r_dir == 2'b00 ? r_x - SHELL_STEP : r_dir == 2'b01 ? r_x + SHELL_STEP : r_x;
  assign w_my   = r_dir == 2'b10 ? r_y + SHELL_STEP : r_dir == 2'b11 ? r_y - SHELL_STEP : r_y;
  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      IDLE: begin
        w_launch = w_fire && w_spawn_ok;
        w_next   = w_launch ? FLIGHT : IDLE;
      end
      FLIGHT: begin
        w_retire = shell_hit || w_edge;
        w_next   = w_retire ? COOLDOWN : FLIGHT;
      end
      COOLDOWN: w_next = r_cd == 6'd0 ? IDLE : COOLDOWN;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_x        <= 10'd0;
      r_y        <= 10'd0;
      r_cd       <= 6'd0;
      r_key_prev <= 1'b0;
      r_fired    <= 1'b0;
      r_dir      <= 2'b01;
    end else begin
      r_state    <= w_next;
      r_key_prev <= w_key;
      r_fired    <= w_launch;
      if (w_launch) begin
        r_x   <= w_sx[9:0];
        r_y   <= w_sy[9:0];
        r_dir <= direction;
      end else if (r_state == FLIGHT && !w_retire) begin
        r_x <= w_mx;
        r_y <= w_my;
      end
      r_cd <= w_retire ? COOLDOWN_FRAMES - 6'd1 :
              (r_state == COOLDOWN && r_cd != 6'd0) ? r_cd - 6'd1 : r_cd;
    end
  end
  assign ShellX       = r_x;
  assign ShellY       = r_y;
  assign ShellS       = SHELL_SIZE;
  assign shell_active = r_state == FLIGHT;
  assign shell_fired  = r_fired;
endmodule

// File: tb/tb_tank_shell.sv
// tb_tank_shell: directed frames push expected outputs into a queue; a negedge monitor pops and checks.
module tb_tank_shell;
  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic [9:0] TankX = 10'd160, TankY = 10'd240, TankS = 10'd8;
  logic [1:0] direction = 2'b01;
  logic       shell_hit = 1'b0;
  logic [9:0] ShellX, ShellY, ShellS;
  logic       shell_active, shell_fired;
  int         n_checks = 0, n_fail = 0;
  typedef struct packed {
    logic       a;
    logic       f;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;
  exp_t  q_exp[$];
  string q_name[$];
  tank_shell dut (
    .frame_clk(clk), .Reset(Reset), .keycode(keycode), .TankX(TankX), .TankY(TankY),
    .TankS(TankS), .direction(direction), .shell_hit(shell_hit), .ShellX(ShellX),
    .ShellY(ShellY), .ShellS(ShellS), .shell_active(shell_active), .shell_fired(shell_fired)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask
  // One frame: let the edge happen, then queue what the outputs must show for that frame.
  task automatic cyc(input string name, input logic a, input logic f, input int x, input int y);
    exp_t e;
    @(posedge clk);
    #1;
    e.a = a; e.f = f; e.x = x[9:0]; e.y = y[9:0];
    q_exp.push_back(e);
    q_name.push_back(name);
  endtask
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t  e;
      string n;
      e = q_exp.pop_front();
      n = q_name.pop_front();
      chk({n, ".active"}, {9'd0, shell_active}, {9'd0, e.a});
      chk({n, ".fired"},  {9'd0, shell_fired},  {9'd0, e.f});
      chk({n, ".x"}, ShellX, e.x);
      chk({n, ".y"}, ShellY, e.y);
      chk({n, ".s"}, ShellS, 10'd2);
    end
  end
  task automatic wait_cd(input string name, input int x, input int y);
    for (int i = 0; i < 30; i++) cyc(name, 1'b0, 1'b0, x, y);
  endtask
  initial begin
    cyc("reset", 0, 0, 0, 0);
    Reset = 1'b0;
    cyc("idle", 0, 0, 0, 0);
    keycode = 8'h2C;
    cyc("launch_r", 1, 1, 171, 240);
    cyc("step_r", 1, 0, 175, 240);
    for (int x = 179; x <= 639; x += 4) cyc("fly_r", 1, 0, x, 240);
    cyc("edge_retire", 0, 0, 639, 240);
    keycode = 8'h00;
    wait_cd("cd_edge", 639, 240);
    direction = 2'b11;
    keycode = 8'h2C;
    cyc("launch_up", 1, 1, 160, 229);
    keycode = 8'h00;
    cyc("fly_up2", 1, 0, 160, 225);
    cyc("fly_up3", 1, 0, 160, 221);
    shell_hit = 1'b1;
    cyc("hit", 0, 0, 160, 221);
    shell_hit = 1'b0;
    for (int i = 1; i <= 29; i++) begin
      keycode = (i == 5 || i == 6 || i == 29) ? 8'h2C : 8'h00;
      cyc("cd_ignore", 0, 0, 160, 221);
    end
    keycode = 8'h00;
    cyc("cd_done", 0, 0, 160, 221);
    keycode = 8'h2C;
    cyc("relaunch", 1, 1, 160, 229);
    keycode = 8'h00;
    shell_hit = 1'b1;
    cyc("hit2", 0, 0, 160, 229);
    shell_hit = 1'b0;
    wait_cd("cd2", 160, 229);
    TankX = 10'd300;
    direction = 2'b00;
    keycode = 8'h2C;
    cyc("launch_l", 1, 1, 289, 240);
    keycode = 8'h00;
    direction = 2'b11;
    cyc("latch1", 1, 0, 285, 240);
    cyc("latch2", 1, 0, 281, 240);
    cyc("latch3", 1, 0, 277, 240);
    shell_hit = 1'b1;
    cyc("hit3", 0, 0, 277, 240);
    shell_hit = 1'b0;
    wait_cd("cd3", 277, 240);
    TankX = 10'd5;
    direction = 2'b00;
    keycode = 8'h2C;
    cyc("blocked", 0, 0, 277, 240);
    keycode = 8'h00;
    cyc("blocked_idle", 0, 0, 277, 240);
    TankX = 10'd160;
    direction = 2'b01;
    keycode = 8'h2C;
    cyc("launch_r2", 1, 1, 171, 240);
    cyc("step_r2", 1, 0, 175, 240);
    Reset = 1'b1;
    cyc("reset_mid", 0, 0, 0, 0);
    Reset = 1'b0;
    keycode = 8'h00;
    cyc("after_reset", 0, 0, 0, 0);
    keycode = 8'h2C;
    cyc("launch_post", 1, 1, 171, 240);
    cyc("step_post", 1, 0, 175, 240);
    repeat (4) @(negedge clk);
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
